// File: rtl/pre_if_multi.sv
// Instruction pre-fetch stage. Issues sram-like fetch requests, keeps up to DEPTH
// in-order entries and drops returned data that belongs to flushed requests.
module pre_if_multi #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_exception,
    output logic [4:0]  out_exccode
);

    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [4:0]      EXC_ADEL = 5'h04;

    logic [31:0]      pc;
    logic [31:0]      q_pc     [DEPTH];
    logic [31:0]      q_inst   [DEPTH];
    logic [DEPTH-1:0] q_filled;
    logic [DEPTH-1:0] q_exc;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    fill;
    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    discard;
    logic             halted;

    logic             full;
    logic             fetch_ok;
    logic             push_req;
    logic             push_exc;
    logic             push;
    logic             resp;
    logic             fill_we;
    logic             head_live;
    logic             pop;
    logic [CW-1:0]    inflight_dec;

    assign full     = (count == DEPTH_C);
    assign fetch_ok = !reset && !redirect_valid && !halted && !full;

    assign inst_sram_req  = fetch_ok && (pc[1:0] == 2'b00) && (inflight != DEPTH_C);
    assign inst_sram_addr = pc;

    assign push_req = inst_sram_req && inst_sram_addr_ok;
    assign push_exc = fetch_ok && (pc[1:0] != 2'b00);
    assign push     = push_req || push_exc;

    // data_ok with nothing outstanding is a protocol violation and is ignored
    assign resp         = inst_sram_data_ok && (inflight != '0);
    assign inflight_dec = inflight - CW'(resp);
    assign fill_we      = resp && (discard == '0) && !redirect_valid && !reset;

    assign head_live     = !reset && (count != '0);
    assign out_valid     = head_live && q_filled[head];
    assign out_exception = head_live && q_exc[head];
    assign out_exccode   = out_exception ? EXC_ADEL : 5'd0;
    assign out_pc        = q_pc[head];
    assign out_inst      = q_inst[head];
    assign pop           = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            // every request still outstanding after this cycle must be dropped
            pc       <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            count    <= '0;
            inflight <= inflight_dec;
            discard  <= inflight_dec;
            halted   <= 1'b0;
        end else begin
            if (push_req) pc <= pc + 32'd4;
            if (push_exc) halted <= 1'b1;
            if (push)     tail <= tail + PW'(1);
            if (pop)      head <= head + PW'(1);
            if (fill_we)  fill <= fill + PW'(1);
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight_dec + CW'(push_req);
            if (resp && (discard != '0)) discard <= discard - CW'(1);
        end
    end

    // push and fill never target the same slot: fill only points at unfilled live entries
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]     <= pc;
            q_inst[tail]   <= '0;
            q_filled[tail] <= push_exc;
            q_exc[tail]    <= push_exc;
        end
        if (fill_we) begin
            q_inst[fill]   <= inst_sram_rdata;
            q_filled[fill] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pre_if_multi.sv
// Scoreboard bench for pre_if_multi: a memory model answers fetches in order and a
// reference model predicts the delivered {pc, inst, exception} stream.
module tb_pre_if_multi;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exception;
    logic [4:0]  out_exccode;

    pre_if_multi #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_exception     (out_exception),
        .out_exccode       (out_exccode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] model_pc;
    bit          model_halted;
    bit          dok_real;
    int          dok_mode;
    int          accept_cnt;
    int          n_popped;
    int          n_exc_seen;
    int          n_checks;
    int          n_errors;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // memory responder: returns the oldest outstanding address, in order
    always @(posedge clk) begin
        #2;
        dok_real          = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom();
        if (mem_q.size() > 0 &&
            (dok_mode == 1 || (dok_mode == 2 && $urandom_range(0, 99) < 50))) begin
            inst_sram_data_ok = 1'b1;
            dok_real          = 1'b1;
            inst_sram_rdata   = memf(mem_q[0]);
        end else if (mem_q.size() == 0 && dok_mode == 2 && $urandom_range(0, 99) < 5) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = 32'hDEADDEAD;
        end
    end

    // reference model: memory bookkeeping and expected-stream pushes
    always @(negedge clk) begin
        if (reset) begin
            mem_q.delete();
            exp_q.delete();
            model_pc     = RESET_PC;
            model_halted = 1'b0;
        end else begin
            if (inst_sram_data_ok && dok_real) void'(mem_q.pop_front());
            if (redirect_valid) begin
                check(inst_sram_req == 1'b0, "req_during_redirect", 32'(inst_sram_req), 32'd0);
                exp_q.delete();
                model_pc     = redirect_pc;
                model_halted = (redirect_pc[1:0] != 2'b00);
                if (model_halted) exp_q.push_back('{redirect_pc, 32'd0, 1'b1});
            end else begin
                if (model_halted)
                    check(inst_sram_req == 1'b0, "req_while_halted", 32'(inst_sram_req), 32'd0);
                if (inst_sram_req && inst_sram_addr_ok) begin
                    check(inst_sram_addr == model_pc, "fetch_addr", inst_sram_addr, model_pc);
                    check(mem_q.size() < DEPTH, "inflight_cap", 32'(mem_q.size()), 32'(DEPTH - 1));
                    mem_q.push_back(inst_sram_addr);
                    exp_q.push_back('{model_pc, memf(model_pc), 1'b0});
                    model_pc   = model_pc + 32'd4;
                    accept_cnt++;
                end
            end
        end
    end

    // monitor: compare every delivered entry against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            n_popped++;
            if (out_exception) n_exc_seen++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_out", out_pc, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(out_pc == e.pc, "out_pc", out_pc, e.pc);
                check(out_inst == e.inst, "out_inst", out_inst, e.inst);
                check(out_exception == e.exc, "out_exception", 32'(out_exception), 32'(e.exc));
                check(out_exccode == (e.exc ? 5'h04 : 5'h00), "out_exccode",
                      32'(out_exccode), e.exc ? 32'h4 : 32'h0);
            end
        end
    end

    initial begin
        int base;
        int pops_before;
        logic [31:0] tmp;
        n_checks = 0; n_errors = 0; accept_cnt = 0; n_popped = 0; n_exc_seen = 0;
        dok_mode = 0; dok_real = 1'b0;
        reset = 1'b1; inst_sram_addr_ok = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;

        // reset cycle and the cycle after
        @(negedge clk);
        check(inst_sram_req == 1'b0, "rst_req", 32'(inst_sram_req), 32'd0);
        check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
        check(out_exception == 1'b0, "rst_out_exc", 32'(out_exception), 32'd0);
        check(out_exccode == 5'd0, "rst_exccode", 32'(out_exccode), 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "post_rst_out_valid", 32'(out_valid), 32'd0);
        check(out_exccode == 5'd0, "post_rst_exccode", 32'(out_exccode), 32'd0);
        check(inst_sram_req == 1'b1, "post_rst_req", 32'(inst_sram_req), 32'd1);
        check(inst_sram_addr == RESET_PC, "post_rst_addr", inst_sram_addr, RESET_PC);

        // streaming fetch from RESET_PC
        cyc();
        inst_sram_addr_ok = 1'b1; out_ready = 1'b1; dok_mode = 1;
        repeat (20) cyc();
        check(n_popped >= 15, "stream_throughput", 32'(n_popped), 32'd15);

        // mid-operation reset, then fill up with no data returning
        reset = 1'b1; dok_mode = 0; out_ready = 1'b0;
        cyc();
        reset = 1'b0;
        base = accept_cnt;
        repeat (12) cyc();
        check(accept_cnt - base == DEPTH, "accepts_when_stalled", 32'(accept_cnt - base), 32'(DEPTH));
        @(negedge clk);
        check(inst_sram_req == 1'b0, "req_when_full", 32'(inst_sram_req), 32'd0);
        cyc();
        inst_sram_addr_ok = 1'b0; dok_mode = 1;
        repeat (6) cyc();
        pops_before = n_popped;
        out_ready = 1'b1;
        repeat (8) cyc();
        check(n_popped - pops_before == DEPTH, "drain_after_fill", 32'(n_popped - pops_before), 32'(DEPTH));

        // three outstanding, then redirect: their data must be dropped
        out_ready = 1'b0; dok_mode = 0; inst_sram_addr_ok = 1'b1;
        repeat (3) cyc();
        inst_sram_addr_ok = 1'b0;
        check(mem_q.size() == 3, "outstanding_before_redirect", 32'(mem_q.size()), 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h80000180;
        cyc();
        redirect_valid = 1'b0; inst_sram_addr_ok = 1'b1; dok_mode = 1; out_ready = 1'b1;
        pops_before = n_popped;
        repeat (15) cyc();
        check(n_popped - pops_before >= 5, "post_redirect_flow", 32'(n_popped - pops_before), 32'd5);

        // misaligned redirect target: exception entry and fetch halted
        redirect_valid = 1'b1; redirect_pc = 32'h80000002;
        cyc();
        redirect_valid = 1'b0;
        base = n_exc_seen;
        repeat (20) cyc();
        check(n_exc_seen - base == 1, "adel_entry_seen", 32'(n_exc_seen - base), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h80000180;
        cyc();
        redirect_valid = 1'b0;
        repeat (10) cyc();

        // randomized traffic with redirects, misaligned targets and rare resets
        dok_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            inst_sram_addr_ok = ($urandom_range(0, 99) < 70);
            out_ready         = ($urandom_range(0, 99) < 70);
            redirect_valid    = 1'b0;
            reset             = 1'b0;
            if ($urandom_range(0, 999) < 2) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 99) < 4) begin
                tmp            = $urandom();
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 99) < 85) ? {tmp[31:2], 2'b00}
                                                               : {tmp[31:2], 2'b10};
            end
            cyc();
        end

        // drain: stop redirecting, return all data, accept all output
        reset = 1'b0; redirect_valid = 1'b0; inst_sram_addr_ok = 1'b0;
        out_ready = 1'b1; dok_mode = 1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || mem_q.size() != 0); i++) cyc();
        check(exp_q.size() == 0, "drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check(mem_q.size() == 0, "drain_memory_idle", 32'(mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pre_if_multi.md
PRE_IF_MULTI -- requirements
Module: pre_if_multi

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding fetch requests and the number of buffered entries (power of two, 2..8).
REQ-002 The block SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_sram_req  out  1  fetch request valid (sram-like).
REQ-006 inst_sram_addr  out  32  fetch address (word-aligned PC).
REQ-007 inst_sram_addr_ok  in  1  request accepted this cycle.
REQ-008 inst_sram_data_ok  in  1  oldest outstanding request returns data this cycle.
REQ-009 inst_sram_rdata  in  32  returned instruction word.
REQ-010 redirect_valid  in  1  flush and restart fetch (branch target or exception entry).
REQ-011 redirect_pc  in  32  new fetch PC.
REQ-012 out_valid  out  1  head entry is complete.
REQ-013 out_ready  in  1  downstream accepts head entry.
REQ-014 out_pc  out  32  PC of head entry.
REQ-015 out_inst  out  32  instruction of head entry (0 when out_exception).
REQ-016 out_exception  out  1  head entry carries a fetch exception.
REQ-017 out_exccode  out  5  EXC_AdEL when out_exception, else 0.

Function
REQ-018 State: fetch PC register `pc`; DEPTH-entry in-order queue {pc, inst, filled, exc} with head, tail and fill pointers; `inflight` count (0..DEPTH) of accepted requests not yet returned; `discard` count (0..DEPTH), always <= inflight; `halted` flag.
REQ-019 inst_sram_req SHALL be 1 iff !reset, !redirect_valid, !halted, pc[1:0]==0, queue count < DEPTH and inflight < DEPTH; inst_sram_addr SHALL equal pc.
REQ-020 On req & addr_ok: push {pc, filled=0, exc=0} at tail, inflight+1, pc <= pc+4 (mod 2^32).
REQ-021 If pc[1:0]!=0, !halted, queue not full and no redirect: no request; push {pc, inst=0, filled=1, exc=1} and set halted; halted SHALL clear only on redirect or reset.
REQ-022 On data_ok: inflight-1; if discard>0 then discard-1 and rdata dropped; else write rdata into the entry at the fill pointer, set filled, advance fill pointer.
REQ-023 data_ok with inflight==0 is a protocol violation; the block SHALL ignore it (no state change).
REQ-024 out_valid SHALL equal queue non-empty & head.filled; fields come combinationally from the head entry; pop on out_valid & out_ready & !redirect_valid.
REQ-025 Latency: a request accepted in cycle N whose data_ok arrives in cycle M SHALL present out_valid in cycle M+1 at the earliest.
REQ-026 On redirect_valid: queue emptied (head=tail=fill), pc <= redirect_pc, halted <= 0, discard <= inflight after this cycle's data_ok decrement (i.e. every still-outstanding request); data returned in the redirect cycle is discarded; no pop occurs.
REQ-027 Simultaneous push and pop in one cycle SHALL both take effect; pointers wrap modulo DEPTH; full = count==DEPTH.
REQ-028 Back-to-back redirects SHALL accumulate correctly: discard never exceeds inflight and is never decremented below 0.
REQ-029 Outstanding data SHALL always be attributed in order: the Kth non-discarded data_ok fills the Kth surviving pushed entry.

Reset
REQ-030 On reset: pc <= RESET_PC, queue empty, inflight=0, discard=0, halted=0; outputs in the reset cycle and following cycle: inst_sram_req=0 during reset, out_valid=0, out_exception=0, out_exccode=0.
REQ-031 Reset asserted mid-operation SHALL abandon all outstanding requests without discard tracking; the memory side is reset together with this block.

Verification
REQ-032 Reset then addr_ok=1 each cycle, data_ok 1 cycle after each accept, out_ready=1 -> out_pc sequence BFC00000, BFC00004, BFC00008 with matching rdata, one per cycle after fill.
REQ-033 DEPTH=4, addr_ok=1, data_ok=0, out_ready=0 -> exactly 4 requests accepted, inst_sram_req=0 thereafter; release data_ok x4 -> 4 entries in order.
REQ-034 3 requests outstanding, redirect_valid with redirect_pc=80000180 -> discard=3, next 3 data_ok dropped, first out_pc=80000180.
REQ-035 redirect in the same cycle as data_ok with inflight=2 -> discard=1, queue empty, following single data_ok dropped.
REQ-036 redirect_pc=80000002 -> no request, out_valid with out_exception=1, out_exccode=EXC_AdEL, out_pc=80000002, inst_sram_req stays 0 until next redirect.
